axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DEPTH, 256, memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Port aclk  in  1  system clock; all logic on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports awvalid in 1, awready out 1, awadd in 32: write-address handshake and start byte address.
REQ-006 Ports blen in 6 (beats-1) and btyp in 2 (00 FIXED, 01 INCR, 10 WRAP, 11 reserved): shared burst sideband.
REQ-007 Ports wvalid in 1, wready out 1, wdata in 32, wlast in 1: write-data channel.
REQ-008 Ports bvalid out 1, bready in 1, bresp out 2 (00 OKAY, 10 SLVERR): write response.
REQ-009 Ports arvalid in 1, aready out 1, aradd in 32: read-address handshake.
REQ-010 Ports rvalid out 1, rready in 1, rdata out 32, rlast out 1, rcount out 6 (current beat index): read-data channel.

Function
REQ-011 blen/btyp SHALL be sampled only on the awvalid&awready or arvalid&aready cycle; each channel keeps its own copy.
REQ-012 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); transitions on AW handshake, on the final beat, and on bready.
REQ-013 Read FSM SHALL have states R_IDLE (aready=1) and R_DATA (rvalid=1); it runs independently of and concurrently with the write FSM.
REQ-014 Word index SHALL be address[ADDR_W-1:2]; address bits [1:0] are ignored.
REQ-015 Next address: FIXED unchanged; INCR +4; WRAP +4 wrapping within an aligned (blen+1)*4-byte window.
REQ-016 WRAP with blen+1 not in {2,4,8,16}, or btyp=11, SHALL execute as INCR and flag SLVERR.
REQ-017 Each wvalid&wready beat SHALL write wdata to the current word in that cycle; the burst SHALL end after exactly blen+1 beats.
REQ-018 wlast asserted on a non-final beat, or absent on the final beat, SHALL set bresp=SLVERR; the beat count still governs burst end.
REQ-019 A beat with word index >= DEPTH SHALL not write memory, SHALL return rdata=0, and SHALL set bresp=SLVERR for write bursts.
REQ-020 bvalid SHALL rise the cycle after the final W beat and hold with stable bresp until bready.
REQ-021 The first rvalid SHALL assert the cycle after the AR handshake; rdata/rlast/rcount SHALL hold stable while rvalid&!rready.
REQ-022 With rready held high, beats SHALL stream one per cycle; rlast=1 only when rcount==blen; R_IDLE follows the rlast beat.
REQ-023 A read and a write to the same word in the same cycle SHALL return the pre-write value.
REQ-024 A new AW/AR SHALL NOT be accepted until the current burst on that channel returns to IDLE.

Reset
REQ-025 While reset=1, all outputs SHALL be 0 and both FSMs IDLE; awready=aready=1 in the first cycle after release.
REQ-026 Reset mid-burst SHALL abandon the burst without a response; memory contents SHALL NOT be cleared.

Configuration
REQ-027 Macro AXI_SLV_WRAP_EN defined: WRAP is supported per REQ-015/016; undefined: btyp=10 is treated as reserved (INCR + SLVERR).

Structure
REQ-028 Package axi_pkg SHALL hold the burst-type and response enums, the W/R FSM state enums, and the beat-size constant (4).
REQ-029 Next-address computation SHALL be a sub-module axi_addr_gen, instantiated once per channel.

Verification
REQ-030 INCR write: awadd=0x10, blen=3, wdata 0xA0..0xA3, wlast on beat 3 -> bresp=00; read back gives 0xA0..0xA3, rlast on rcount=3.
REQ-031 WRAP read: aradd=0x18, blen=3 -> words 6,7,4,5 in order; without AXI_SLV_WRAP_EN -> words 6,7,8,9.
REQ-032 Backpressure: rready low for 3 cycles mid-burst -> rdata/rcount stable; no beat lost or duplicated.
REQ-033 Error: awadd=DEPTH*4, blen=0 -> no write, bresp=10; early wlast on beat 1 of blen=3 -> 4 beats accepted, bresp=10.
REQ-034 Reset asserted during beat 2 of a 4-beat write -> FSM IDLE, no bvalid, words 0-1 of the burst retain written data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared burst/response encodings, FSM state types and burst legality check.
// Define AXI_SLV_WRAP_EN to accept WRAP bursts; otherwise WRAP is treated as reserved.
package axi_pkg;

    localparam int BEAT_BYTES = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // An illegal burst still executes, as INCR, but must be flagged.
    function automatic logic burst_err(input logic [5:0] len, input logic [1:0] typ);
        logic err;
        err = 1'b1;
        if (typ == BURST_FIXED || typ == BURST_INCR) begin
            err = 1'b0;
        end else if (typ == BURST_WRAP) begin
`ifdef AXI_SLV_WRAP_EN
            err = !(len == 6'd1 || len == 6'd3 || len == 6'd7 || len == 6'd15);
`else
            err = 1'b1;
`endif
        end
        return err;
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// Burst memory slave bus: AW/W/B write channels and AR/R read channels with shared sideband.
interface axi_slave_mem_if #(
    parameter int ADDR_W = 32
);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awadd;
    logic [5:0]        blen;
    logic [1:0]        btyp;
    logic              wvalid, wready, wlast;
    logic [31:0]       wdata;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              arvalid, aready;
    logic [ADDR_W-1:0] aradd;
    logic              rvalid, rready, rlast;
    logic [31:0]       rdata;
    logic [5:0]        rcount;

    modport slave (
        input  awvalid, awadd, blen, btyp, wvalid, wdata, wlast, bready, arvalid, aradd, rready,
        output awready, wready, bvalid, bresp, aready, rvalid, rdata, rlast, rcount
    );

    modport master (
        output awvalid, awadd, blen, btyp, wvalid, wdata, wlast, bready, arvalid, aradd, rready,
        input  awready, wready, bvalid, bresp, aready, rvalid, rdata, rlast, rcount
    );
endinterface

// File: rtl/axi_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts; combinational, zero latency.
// Illegal bursts (see axi_pkg::burst_err) advance as INCR.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [5:0]        len,
    input  logic [1:0]        typ,
    output logic [ADDR_W-1:0] next
);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        incr = addr + ADDR_W'(BEAT_BYTES);
        mask = ADDR_W'({len, 2'b11});
        next = incr;
        if (typ == BURST_FIXED) begin
            next = addr;
        end else if (typ == BURST_WRAP && !burst_err(len, typ)) begin
            // Window is (len+1)*4 bytes and naturally aligned, so only the low bits advance.
            next = (addr & ~mask) | (incr & mask);
        end
    end
endmodule

// File: rtl/axi_slave_mem.sv
// Single-port-per-channel burst memory slave; first R beat one cycle after AR, B one cycle after last W.
// Independent read/write FSMs; stalls hold R outputs. Build option: AXI_SLV_WRAP_EN enables WRAP bursts.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic            aclk,
    input  logic            reset,
    axi_slave_mem_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word;
        word = {2'b00, a[ADDR_W-1:2]};
        return word < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
        return in_range(a) ? mem[widx(a)] : 32'd0;
    endfunction

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr, w_next;
    logic [5:0]        w_len, w_cnt;
    logic [1:0]        w_typ;
    logic              w_err, aw_hs, w_beat, w_final;

    axi_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (.addr(w_addr), .len(w_len), .typ(w_typ), .next(w_next));

    assign bus.awready = !reset && (w_state == W_IDLE);
    assign bus.wready  = !reset && (w_state == W_DATA);
    assign bus.bvalid  = !reset && (w_state == W_RESP);
    assign bus.bresp   = (bus.bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_beat      = bus.wvalid && bus.wready;
    assign w_final     = (w_cnt == w_len);

    always_ff @(posedge aclk) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_typ   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_addr  <= bus.awadd;
                    w_len   <= bus.blen;
                    w_typ   <= bus.btyp;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    // Beat count alone ends the burst; a misplaced wlast only poisons the response.
                    w_err   <= w_err | burst_err(w_len, w_typ) | !in_range(w_addr)
                             | (bus.wlast != w_final);
                    w_addr  <= w_next;
                    w_cnt   <= w_cnt + 6'd1;
                    if (w_final) w_state <= W_RESP;
                end
                W_RESP: if (bus.bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_beat && in_range(w_addr)) mem[widx(w_addr)] <= bus.wdata;
    end

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr, r_next;
    logic [5:0]        r_len, r_cnt;
    logic [1:0]        r_typ;
    logic [31:0]       r_dat;
    logic              ar_hs, r_beat;

    axi_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (.addr(r_addr), .len(r_len), .typ(r_typ), .next(r_next));

    assign bus.aready = !reset && (r_state == R_IDLE);
    assign bus.rvalid = !reset && (r_state == R_DATA);
    assign bus.rlast  = bus.rvalid && (r_cnt == r_len);
    assign bus.rdata  = bus.rvalid ? r_dat : 32'd0;
    assign bus.rcount = bus.rvalid ? r_cnt : 6'd0;
    assign ar_hs      = bus.arvalid && bus.aready;
    assign r_beat     = bus.rvalid && bus.rready;

    // rdata is registered so a same-cycle write to the word is not visible until the next fetch.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_typ   <= '0;
            r_cnt   <= '0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_addr  <= bus.aradd;
                    r_len   <= bus.blen;
                    r_typ   <= bus.btyp;
                    r_cnt   <= '0;
                    r_dat   <= rd_word(bus.aradd);
                    r_state <= R_DATA;
                end
                R_DATA: if (r_beat) begin
                    if (bus.rlast) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_addr <= r_next;
                        r_cnt  <= r_cnt + 6'd1;
                        r_dat  <= rd_word(r_next);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bursts against axi_slave_mem; expected B/R beats queued at issue, checked by a negedge monitor.
module tb_axi_slave_mem;
    import axi_pkg::*;

    localparam int DEPTH = 256;

    logic aclk  = 1'b0;
    logic reset = 1'b1;
    always #5 aclk = ~aclk;

    axi_slave_mem_if #(.ADDR_W(32)) bus ();

    axi_slave_mem #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .aclk  (aclk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] d;
        logic [5:0]  c;
        logic        l;
    } rbeat_t;

    int          tests  = 0;
    int          failed = 0;
    int          r_seen = 0;
    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    rbeat_t      mon_e;
    logic [1:0]  mon_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        failed++;
        $display("FAIL %s: event seen, expected none", name);
    endtask

    // Scoreboard monitor: every presented R beat (stalled or not) and every B handshake.
    always @(negedge aclk) begin
        if (!reset) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) begin
                    flag("unexpected_bvalid");
                end else begin
                    mon_b = exp_b.pop_front();
                    check("bresp", {30'd0, bus.bresp}, {30'd0, mon_b});
                end
            end
            if (bus.rvalid) begin
                if (exp_r.size() == 0) begin
                    flag("unexpected_rvalid");
                end else begin
                    mon_e = exp_r[0];
                    check("rdata", bus.rdata, mon_e.d);
                    check("rcount", {26'd0, bus.rcount}, {26'd0, mon_e.c});
                    check("rlast", {31'd0, bus.rlast}, {31'd0, mon_e.l});
                    if (bus.rready) begin
                        void'(exp_r.pop_front());
                        r_seen++;
                    end
                end
            end
        end
    end

    function automatic logic rdy_of(input int which);
        case (which)
            0:       return bus.awready;
            1:       return bus.wready;
            default: return bus.aready;
        endcase
    endfunction

    // Entered just after a posedge with valid driven; returns just after the handshake edge.
    task automatic wait_hs(input string name, input int which);
        int n;
        n = 0;
        @(negedge aclk);
        while (!rdy_of(which) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!rdy_of(which)) flag(name);
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (exp_r.size() != 0 || exp_b.size() != 0) begin
            flag("drain_timeout");
            exp_r.delete();
            exp_b.delete();
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [5:0] len, input logic [1:0] typ,
                            input logic [31:0] base, input int wlast_at, input int abort_at,
                            input logic [1:0] resp);
        if (abort_at < 0) exp_b.push_back(resp);
        bus.awvalid = 1'b1;
        bus.awadd   = addr;
        bus.blen    = len;
        bus.btyp    = typ;
        wait_hs("aw_timeout", 0);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = base + 32'(i);
            bus.wlast  = (i == wlast_at);
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge aclk);
                #1;
                @(posedge aclk);
                #1;
                reset      = 1'b0;
                bus.wvalid = 1'b0;
                bus.wlast  = 1'b0;
                return;
            end
            wait_hs("w_timeout", 1);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        wait_drain();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [5:0] len, input logic [1:0] typ,
                           input logic [31:0] ex [4], input bit stall);
        rbeat_t b;
        int     n;
        int     target;
        for (int i = 0; i <= int'(len); i++) begin
            b.d = ex[i];
            b.c = 6'(i);
            b.l = (i == int'(len));
            exp_r.push_back(b);
        end
        target      = r_seen + 2;
        bus.arvalid = 1'b1;
        bus.aradd   = addr;
        bus.blen    = len;
        bus.btyp    = typ;
        wait_hs("ar_timeout", 2);
        bus.arvalid = 1'b0;
        if (stall) begin
            n = 0;
            while (r_seen < target && n < 50) begin
                @(posedge aclk);
                #1;
                n++;
            end
            bus.rready = 1'b0;
            repeat (3) begin
                @(posedge aclk);
                #1;
            end
            bus.rready = 1'b1;
        end
        wait_drain();
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awadd = '0; bus.blen = '0; bus.btyp = '0;
        bus.wvalid  = 1'b0; bus.wdata = '0; bus.wlast = 1'b0; bus.bready = 1'b1;
        bus.arvalid = 1'b0; bus.aradd = '0; bus.rready = 1'b1;

        repeat (2) @(negedge aclk);
        check("rst_awready", {31'd0, bus.awready}, 32'd0);
        check("rst_aready", {31'd0, bus.aready}, 32'd0);
        check("rst_wready", {31'd0, bus.wready}, 32'd0);
        check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        @(posedge aclk);
        #1;
        reset = 1'b0;
        @(negedge aclk);
        check("post_rst_awready", {31'd0, bus.awready}, 32'd1);
        check("post_rst_aready", {31'd0, bus.aready}, 32'd1);
        @(posedge aclk);
        #1;

        do_write(32'h10, 6'd3, BURST_INCR, 32'hA0, 3, -1, RESP_OKAY);
        do_read(32'h10, 6'd3, BURST_INCR, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b0);
        do_write(32'h20, 6'd1, BURST_INCR, 32'hB8, 1, -1, RESP_OKAY);
`ifdef AXI_SLV_WRAP_EN
        do_read(32'h18, 6'd3, BURST_WRAP, '{32'hA2, 32'hA3, 32'hA0, 32'hA1}, 1'b0);
`else
        do_read(32'h18, 6'd3, BURST_WRAP, '{32'hA2, 32'hA3, 32'hB8, 32'hB9}, 1'b0);
`endif
        do_read(32'h10, 6'd3, BURST_INCR, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b1);

        do_write(32'h70, 6'd2, BURST_WRAP, 32'h70, 2, -1, RESP_SLVERR);
        do_read(32'h70, 6'd2, BURST_INCR, '{32'h70, 32'h71, 32'h72, 32'h0}, 1'b0);
        do_write(32'h40, 6'd1, BURST_RSVD, 32'hF0, 1, -1, RESP_SLVERR);
        do_read(32'h40, 6'd1, BURST_INCR, '{32'hF0, 32'hF1, 32'h0, 32'h0}, 1'b0);
        do_write(32'h60, 6'd2, BURST_FIXED, 32'hD0, 2, -1, RESP_OKAY);
        do_read(32'h60, 6'd0, BURST_INCR, '{32'hD2, 32'h0, 32'h0, 32'h0}, 1'b0);
        do_write(32'h50, 6'd3, BURST_INCR, 32'hE0, 1, -1, RESP_SLVERR);
        do_read(32'h50, 6'd3, BURST_INCR, '{32'hE0, 32'hE1, 32'hE2, 32'hE3}, 1'b0);

        do_write(32'h0, 6'd3, BURST_INCR, 32'hC0, 3, 2, RESP_OKAY);
        repeat (3) begin
            @(negedge aclk);
            check("abort_bvalid", {31'd0, bus.bvalid}, 32'd0);
            check("abort_wready", {31'd0, bus.wready}, 32'd0);
            check("abort_awready", {31'd0, bus.awready}, 32'd1);
        end
        @(posedge aclk);
        #1;
        do_read(32'h0, 6'd1, BURST_INCR, '{32'hC0, 32'hC1, 32'h0, 32'h0}, 1'b0);

        do_write(32'(DEPTH * 4), 6'd0, BURST_INCR, 32'hDEAD, 0, -1, RESP_SLVERR);
        do_read(32'(DEPTH * 4), 6'd0, BURST_INCR, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0);
        do_read(32'h0, 6'd0, BURST_INCR, '{32'hC0, 32'h0, 32'h0, 32'h0}, 1'b0);

        repeat (2) @(posedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
